// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, sequential advance, stall hold and
// redirect flush into the IF/ID register. Optional perf counters under IF_STAGE_PERF_EN.
module if_stage #(
   parameter int PC_SIZE    = 11,
   parameter int INSTR_SIZE = 32,
   parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [PC_SIZE-1:0]    redirect_pc,
   input  logic [INSTR_SIZE-1:0] instr_in,
   output logic [PC_SIZE-1:0]    pc,
   output logic [INSTR_SIZE-1:0] ifid_instr,
   output logic [PC_SIZE-1:0]    ifid_pc_plus1,
`ifdef IF_STAGE_PERF_EN
   output logic [31:0]           perf_fetched,
   output logic [31:0]           perf_stalls,
`endif
   output logic                  ifid_valid
);

   logic [PC_SIZE-1:0] pc_next_seq;
   logic               advance;

   // Modulo-2^PC_SIZE increment; all-ones wraps to zero without any flag.
   assign pc_next_seq = pc + 1'b1;
   assign advance     = !redirect && !stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc            <= RESET_PC;
         ifid_instr    <= '0;
         ifid_pc_plus1 <= '0;
         ifid_valid    <= 1'b0;
      end else if (redirect) begin
         // Wrong-path fetch is discarded even if a stall was pending.
         pc            <= redirect_pc;
         ifid_instr    <= '0;
         ifid_pc_plus1 <= '0;
         ifid_valid    <= 1'b0;
      end else if (!stall) begin
         pc            <= pc_next_seq;
         ifid_instr    <= instr_in;
         ifid_pc_plus1 <= pc_next_seq;
         ifid_valid    <= 1'b1;
      end
   end

`ifdef IF_STAGE_PERF_EN
   // Both counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stalls  <= '0;
      end else begin
         if (advance && (perf_fetched != 32'hFFFF_FFFF))
            perf_fetched <= perf_fetched + 32'd1;
         if (stall && !redirect && (perf_stalls != 32'hFFFF_FFFF))
            perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule
